// File: rtl/sram_fifo_pkg.sv
// Shared widths, types and pointer helper for the 1rw+1r SRAM FIFO controller.
// The optional SRAM_FIFO_BYPASS_EN feature lives in sram_1rw_1r_fifo_ctrl.
package sram_fifo_pkg;

    localparam int DFLT_ADDR_WIDTH = 4;
    localparam int DFLT_DATA_WIDTH = 2;
    localparam int DEPTH           = 2 ** DFLT_ADDR_WIDTH;

    typedef logic [DFLT_ADDR_WIDTH-1:0] ptr_t;
    typedef logic [DFLT_DATA_WIDTH-1:0] word_t;
    typedef logic [DFLT_ADDR_WIDTH+1:0] cnt_t;

    // Wrapping increment for an aw-bit pointer carried in a 32-bit container.
    function automatic logic [31:0] ptr_inc(input logic [31:0] p, input int aw);
        logic [31:0] mask;
        mask = (32'd1 << aw) - 32'd1;
        return (p + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/sram_fifo_outbuf.sv
// Two-entry output buffer that absorbs the SRAM read latency.
// Only the control state is reset; stored words are qualified by bcnt.
module sram_fifo_outbuf #(
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            bcnt,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_idx;
    logic                  rd_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt   <= 2'd0;
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
        end else begin
            if (push) wr_idx <= ~wr_idx;
            if (pop)  rd_idx <= ~rd_idx;
            bcnt <= bcnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= push_data;
    end

    assign head = mem[rd_idx];

endmodule

// File: rtl/sram_1rw_1r_fifo_ctrl.sv
// FIFO controller in front of a 1rw+1r SRAM macro; port 0 writes, port 1 reads.
// Define SRAM_FIFO_BYPASS_EN to let pushes into an idle, empty FIFO skip the SRAM.
module sram_1rw_1r_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DFLT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);

    localparam logic [ADDR_WIDTH:0] SCNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   scnt;
    logic                  inflight;
    logic [1:0]            bcnt;
    logic [DATA_WIDTH-1:0] head;

    logic                  push_req;
    logic                  pop;
    logic                  rd;
    logic                  byp;
    logic                  sram_wr;
    logic                  buf_push;
    logic [DATA_WIDTH-1:0] buf_din;
    logic [2:0]            occ_after;

    assign in_ready  = !rst && (scnt != SCNT_FULL);
    assign push_req  = in_valid && in_ready;
    assign out_valid = (bcnt != 2'd0);
    assign pop       = out_valid && out_ready;

    // Buffer slots still claimed next cycle; a new read may only be issued if one stays free.
    assign occ_after = 3'(bcnt) + 3'(inflight) - 3'(pop);
    assign rd        = !rst && (scnt != '0) && (occ_after < 3'd2);

`ifdef SRAM_FIFO_BYPASS_EN
    logic [2:0] buf_after_pop;
    assign buf_after_pop = 3'(bcnt) - 3'(pop);
    assign byp = push_req && (scnt == '0) && !inflight && (buf_after_pop < 3'd2);
`else
    assign byp = 1'b0;
`endif

    assign sram_wr  = push_req && !byp;
    // Bypass needs inflight==0, so the two buffer sources never collide.
    assign buf_push = inflight || byp;
    assign buf_din  = inflight ? dout1 : in_data;

    assign csb0  = !sram_wr;
    assign web0  = 1'b0;
    assign addr0 = wptr;
    assign din0  = in_data;
    assign csb1  = !rd;
    assign addr1 = rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            scnt     <= '0;
            inflight <= 1'b0;
        end else begin
            if (sram_wr) wptr <= ADDR_WIDTH'(ptr_inc(32'(wptr), ADDR_WIDTH));
            if (rd)      rptr <= ADDR_WIDTH'(ptr_inc(32'(rptr), ADDR_WIDTH));
            inflight <= rd;
            case ({sram_wr, rd})
                2'b10:   scnt <= scnt + 1'b1;
                2'b01:   scnt <= scnt - 1'b1;
                default: scnt <= scnt;
            endcase
        end
    end

    sram_fifo_outbuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_outbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (buf_din),
        .pop       (pop),
        .bcnt      (bcnt),
        .head      (head)
    );

    // Stored words are not reset, so the empty buffer presents zero.
    assign out_data = out_valid ? head : '0;
    assign count    = (ADDR_WIDTH+2)'(scnt) + (ADDR_WIDTH+2)'(inflight) + (ADDR_WIDTH+2)'(bcnt);

    a_no_same_addr: assert property (@(posedge clk) disable iff (rst)
        !(!csb0 && !csb1 && (addr0 == addr1)));
    a_buf_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(buf_push && (bcnt == 2'd2) && !pop));

endmodule

// File: tb/tb_sram_1rw_1r_fifo_ctrl.sv
// Bench for sram_1rw_1r_fifo_ctrl with a behavioural 1rw+1r SRAM and a scoreboard queue.
module tb_sram_1rw_1r_fifo_ctrl;
    import sram_fifo_pkg::*;

    localparam int AW = DFLT_ADDR_WIDTH;
    localparam int DW = DFLT_DATA_WIDTH;
    localparam int NV = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    word_t         in_data;
    logic          out_valid;
    logic          out_ready;
    word_t         out_data;
    logic [AW+1:0] count;
    logic          csb0;
    logic          web0;
    ptr_t          addr0;
    word_t         din0;
    logic          csb1;
    ptr_t          addr1;
    word_t         dout1;

    word_t sram [DEPTH];

    int    checks   = 0;
    int    failures = 0;
    word_t sb [$];
    ptr_t  wptr_m;
    ptr_t  rptr_m;
    logic  in_fire;
    logic  out_fire;

    typedef struct {
        logic          iv;
        word_t         d;
        logic          ordy;
        logic          csb0;
        ptr_t          a0;
        logic          csb1;
        ptr_t          a1;
        logic          ov;
        word_t         od;
        logic [AW+1:0] cnt;
    } vec_t;

    vec_t vt [NV];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!csb0 && !web0) sram[addr0] <= din0;
        if (!csb1) dout1 <= sram[addr1];
    end

    sram_1rw_1r_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .csb0      (csb0),
        .web0      (web0),
        .addr0     (addr0),
        .din0      (din0),
        .csb1      (csb1),
        .addr1     (addr1),
        .dout1     (dout1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at the negedge: per-cycle invariants, address model and scoreboard.
    task automatic monitor();
        check("count_vs_sb", 32'(count), 32'(sb.size()));
        check("web0", 32'(web0), 32'd0);
        if (!csb0 && !csb1) check("same_addr_rw", 32'(addr0 != addr1), 32'd1);
        if (!csb0) begin
            check("addr0", 32'(addr0), 32'(wptr_m));
            check("din0", 32'(din0), 32'(in_data));
            wptr_m++;
        end
        if (!csb1) begin
            check("addr1", 32'(addr1), 32'(rptr_m));
            rptr_m++;
        end
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (in_fire) sb.push_back(in_data);
        if (out_fire) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_underflow: actual=%0h required=none", out_data);
            end else begin
                check("pop_data", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  pushed;
        int  popped;
        int  gap;
        logic started;
        logic seen_ready;

`ifdef SRAM_FIFO_BYPASS_EN
        //           iv    d      ordy  csb0  a0    csb1  a1    ov    od     cnt
        vt[0] = '{1'b1, 2'b10, 1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 2'b00, 6'd0};
        vt[1] = '{1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 2'b10, 6'd1};
        vt[2] = '{1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 2'b10, 6'd1};
        vt[3] = '{1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 2'b10, 6'd1};
        vt[4] = '{1'b0, 2'b00, 1'b1, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 2'b10, 6'd1};
        vt[5] = '{1'b1, 2'b11, 1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 2'b00, 6'd0};
        vt[6] = '{1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 2'b11, 6'd1};
        vt[7] = '{1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 2'b11, 6'd1};
        vt[8] = '{1'b0, 2'b00, 1'b1, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 2'b11, 6'd1};
        vt[9] = '{1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 2'b00, 6'd0};
`else
        vt[0] = '{1'b1, 2'b10, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 2'b00, 6'd0};
        vt[1] = '{1'b0, 2'b00, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 2'b00, 6'd1};
        vt[2] = '{1'b0, 2'b00, 1'b0, 1'b1, 4'd1, 1'b1, 4'd1, 1'b0, 2'b00, 6'd1};
        vt[3] = '{1'b0, 2'b00, 1'b0, 1'b1, 4'd1, 1'b1, 4'd1, 1'b1, 2'b10, 6'd1};
        vt[4] = '{1'b0, 2'b00, 1'b1, 1'b1, 4'd1, 1'b1, 4'd1, 1'b1, 2'b10, 6'd1};
        vt[5] = '{1'b1, 2'b11, 1'b0, 1'b0, 4'd1, 1'b1, 4'd1, 1'b0, 2'b00, 6'd0};
        vt[6] = '{1'b0, 2'b00, 1'b0, 1'b1, 4'd2, 1'b0, 4'd1, 1'b0, 2'b00, 6'd1};
        vt[7] = '{1'b0, 2'b00, 1'b0, 1'b1, 4'd2, 1'b1, 4'd2, 1'b0, 2'b00, 6'd1};
        vt[8] = '{1'b0, 2'b00, 1'b1, 1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 2'b11, 6'd1};
        vt[9] = '{1'b0, 2'b00, 1'b0, 1'b1, 4'd2, 1'b1, 4'd2, 1'b0, 2'b00, 6'd0};
`endif

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        wptr_m = '0; rptr_m = '0;

        // Reset state, with a push offered to show csb0 is held off.
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("rst_csb0", 32'(csb0), 32'd1);
        check("rst_csb1", 32'(csb1), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-word latency vectors.
        for (int i = 0; i < NV; i++) begin
            in_valid  = vt[i].iv;
            in_data   = vt[i].d;
            out_ready = vt[i].ordy;
            @(negedge clk);
            check($sformatf("v%0d_csb0", i), 32'(csb0), 32'(vt[i].csb0));
            check($sformatf("v%0d_addr0", i), 32'(addr0), 32'(vt[i].a0));
            check($sformatf("v%0d_csb1", i), 32'(csb1), 32'(vt[i].csb1));
            check($sformatf("v%0d_addr1", i), 32'(addr1), 32'(vt[i].a1));
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].ov));
            check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vt[i].od));
            check($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].cnt));
            monitor();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;

        // Fill to capacity with out_ready low.
        n = 0;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 100 && n < 18; cyc++) begin
            in_data = word_t'(n);
            tick();
            if (in_fire) n++;
        end
        check("fill_accepted", 32'(n), 32'd18);
        in_data = 2'b01;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("full_no_accept", 32'(in_fire), 32'd0);
        end
        check("full_count", 32'(count), 32'd18);
        check("full_in_ready", 32'(in_ready), 32'd0);

        // First pop issues a read but in_ready only returns next cycle.
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("pop_rd_issue", 32'(csb1), 32'd0);
        check("pop_in_ready_same", 32'(in_ready), 32'd0);
        monitor();
        @(posedge clk);
        #1;
        check("pop_in_ready_next", 32'(in_ready), 32'd1);
        seen_ready = in_ready;
        for (int cyc = 0; cyc < 80 && sb.size() > 0; cyc++) tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("drain_in_ready", 32'(seen_ready), 32'd1);
        tick();
        check("drain_count", 32'(count), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // Continuous streaming across pointer wrap.
        pushed = 0; popped = 0; gap = 0; started = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && popped < 40; cyc++) begin
            in_valid = (pushed < 40);
            in_data  = word_t'($urandom);
            tick();
            if (in_fire) pushed++;
            if (out_fire) begin
                started = 1'b1;
                popped++;
            end else if (started && popped < 40) begin
                gap++;
            end
        end
        check("stream_popped", 32'(popped), 32'd40);
        check("stream_gaps", 32'(gap), 32'd0);
        in_valid = 1'b0;
        tick();

        // Random stalls on both sides.
        pushed = 0; popped = 0;
        for (int cyc = 0; cyc < 4000 && (pushed < 200 || sb.size() > 0); cyc++) begin
            in_valid  = (pushed < 200) && ($urandom_range(0, 3) != 0);
            in_data   = word_t'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (in_fire)  pushed++;
            if (out_fire) popped++;
        end
        check("rand_pushed", 32'(pushed), 32'd200);
        check("rand_popped", 32'(popped), 32'd200);
        check("rand_drained", 32'(sb.size()), 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;
        tick();

        // Mid-stream reset with a read in flight.
        n = 0;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 9; cyc++) begin
            in_data = word_t'(n + 1);
            tick();
            if (in_fire) n++;
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_count_pre", 32'(count), 32'd9);
        in_valid = 1'b1; in_data = 2'b11; out_ready = 1'b1;
        @(negedge clk);
        check("mid_rd_issue", 32'(csb1), 32'd0);
        monitor();
        @(posedge clk);
        #1;
        check("mid_count", 32'(count), 32'd9);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_csb0", 32'(csb0), 32'd1);
        check("mid_rst_csb1", 32'(csb1), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sb.delete();
        wptr_m = '0; rptr_m = '0;
        @(posedge clk);
        #1;
        check("post_rst_count", 32'(count), 32'd0);
        in_valid = 1'b1; in_data = 2'b01;
        tick();
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 6 && !out_valid; cyc++) tick();
        check("post_rst_out_valid", 32'(out_valid), 32'd1);
        check("post_rst_out_data", 32'(out_data), 32'h1);
        check("post_rst_count1", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check("post_rst_empty", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
